// File: rtl/code_seq_pkg.sv
// Shared definitions for the code sequencer: state encoding, default widths, code range.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package code_seq_pkg;

    localparam int DW_DEF    = 3;
    localparam int LW_DEF    = 5;
    localparam int RANGE_MAX = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/code_step.sv
// Next-code unit: cur + step, wrapping mod 2^DW, or mod RANGE_MAX when CODE_RANGE_LIMIT_EN is defined.
// Latency: combinational.
// Backpressure: none; the caller decides when to take nxt.
module code_step
    import code_seq_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] cur,
    input  logic [DW-1:0] step,
    output logic [DW-1:0] nxt
);

`ifdef CODE_RANGE_LIMIT_EN
    localparam logic [DW:0] RMAX_W = (DW+1)'(RANGE_MAX);

    // Both operands are already below RANGE_MAX, so one conditional subtract is a full mod.
    logic [DW:0] sum;
    assign sum = {1'b0, cur} + {1'b0, step};

    // Fold the sum back into 0..RANGE_MAX-1.
    always_comb begin
        nxt = sum[DW-1:0];
        if (sum >= RMAX_W) begin
            nxt = DW'(sum - RMAX_W);
        end
    end
`else
    assign nxt = cur + step;
`endif

endmodule

// File: rtl/code_sequencer.sv
// Emits a burst of burst_len codes start_code, +step, ... on a valid/ready port; optional
// range limit via CODE_RANGE_LIMIT_EN. Latency: first code valid one cycle after start.
// Backpressure: ready low holds data_out/valid/count; abort ends the burst without done.
module code_sequencer
    import code_seq_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] start_code,
    input  logic [DW-1:0] step,
    input  logic [LW-1:0] burst_len,
    input  logic          abort,
    input  logic          ready,
    output logic [DW-1:0] data_out,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] count,
    output logic          range_err
);

    state_t        state;
    logic [DW-1:0] step_q;
    logic [LW-1:0] len_q;
    logic [DW-1:0] nxt_code;
    logic [DW-1:0] step_norm;
    logic          code_ok;
    logic          xfer;
    logic [LW-1:0] count_inc;

`ifdef CODE_RANGE_LIMIT_EN
    localparam logic [DW-1:0] RMAX = DW'(RANGE_MAX);
    assign code_ok   = (start_code < RMAX);
    assign step_norm = step % RMAX;
`else
    assign code_ok   = 1'b1;
    assign step_norm = step;
`endif

    assign xfer      = valid && ready;
    assign count_inc = count + LW'(1);

    code_step #(.DW(DW)) u_step (
        .cur  (data_out),
        .step (step_q),
        .nxt  (nxt_code)
    );

    // Burst FSM; every output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            data_out  <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            range_err <= 1'b0;
            step_q    <= '0;
            len_q     <= '0;
        end else begin
            done      <= 1'b0;
            range_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A zero-length start is dropped silently, before the range check.
                    if (start && burst_len != '0) begin
                        if (!code_ok) begin
                            range_err <= 1'b1;
                        end else begin
                            state    <= ST_RUN;
                            data_out <= start_code;
                            valid    <= 1'b1;
                            busy     <= 1'b1;
                            count    <= '0;
                            step_q   <= step_norm;
                            len_q    <= burst_len;
                        end
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        count <= count_inc;
                    end
                    // Abort beats the final transfer: the transfer counts, done does not fire.
                    if (abort) begin
                        state <= ST_IDLE;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end else if (xfer) begin
                        if (count_inc == len_q) begin
                            state <= ST_DONE;
                            valid <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            data_out <= nxt_code;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_sequencer.sv
// Scoreboard bench for code_sequencer: expected codes are queued at start and popped per transfer.
// Latency: n/a.
// Backpressure: ready is toggled by the stimulus to exercise stalls.
module tb_code_sequencer;

    localparam int DW = 3;
    localparam int LW = 5;
`ifdef CODE_RANGE_LIMIT_EN
    localparam int M = 6;
`else
    localparam int M = 8;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] start_code;
    logic [DW-1:0] step;
    logic [LW-1:0] burst_len;
    logic          abort;
    logic          ready;
    logic [DW-1:0] data_out;
    logic          valid;
    logic          busy;
    logic          done;
    logic [LW-1:0] count;
    logic          range_err;

    int checks    = 0;
    int failures  = 0;
    int done_seen = 0;
    int exp_q[$];
    int d0;

    code_sequencer #(.DW(DW), .LW(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_code (start_code),
        .step       (step),
        .burst_len  (burst_len),
        .abort      (abort),
        .ready      (ready),
        .data_out   (data_out),
        .valid      (valid),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .range_err  (range_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start for one cycle and queue the codes the burst should produce.
    task automatic go(input int code, input int stp, input int len);
        int c;
        int s;
        c = code;
        s = stp % M;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(c);
            c = (c + s) % M;
        end
        start      = 1'b1;
        start_code = DW'(code);
        step       = DW'(stp);
        burst_len  = LW'(len);
        tick();
        start = 1'b0;
    endtask

    // Scoreboard: inputs only change just after a rising edge, so the falling edge sees what the next edge will.
    always @(negedge clk) begin
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
                chk("code", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
        if (done) done_seen++;
    end

    initial begin
        rst = 1'b1; start = 1'b0; start_code = '0; step = '0; burst_len = '0;
        abort = 1'b0; ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", 32'(data_out), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_range_err", 32'(range_err), 0);
        rst = 1'b0;

`ifndef CODE_RANGE_LIMIT_EN
        // Full-range wrap 1..7,0 back to back.
        d0 = done_seen;
        go(1, 1, 8);
        chk("b1_valid", 32'(valid), 1);
        chk("b1_first", 32'(data_out), 1);
        chk("b1_count0", 32'(count), 0);
        chk("b1_busy", 32'(busy), 1);
        repeat (8) tick();
        chk("b1_done", 32'(done), 1);
        chk("b1_count", 32'(count), 8);
        chk("b1_valid_end", 32'(valid), 0);
        chk("b1_busy_done", 32'(busy), 1);
        tick();
        chk("b1_done_clr", 32'(done), 0);
        chk("b1_busy_clr", 32'(busy), 0);
        chk("b1_done_once", 32'(done_seen - d0), 1);
        // Code 7 is legal in full range.
        go(7, 1, 2);
        chk("c7_range_err", 32'(range_err), 0);
        chk("c7_valid", 32'(valid), 1);
        repeat (3) tick();
`else
        // Limited range: 4,5,0,1 and rejection of start_code 7.
        go(4, 1, 4);
        repeat (4) tick();
        chk("lim_done", 32'(done), 1);
        chk("lim_count", 32'(count), 4);
        tick();
        start = 1'b1; start_code = 3'd7; step = 3'd1; burst_len = 5'd3;
        tick();
        start = 1'b0;
        chk("lim_range_err", 32'(range_err), 1);
        chk("lim_rej_valid", 32'(valid), 0);
        chk("lim_rej_busy", 32'(busy), 0);
        tick();
        chk("lim_range_err_clr", 32'(range_err), 0);
        // step 7 behaves as step 1.
        go(0, 7, 3);
        repeat (4) tick();
`endif

        // Stall on 2nd/3rd valid cycles; start during RUN must be ignored.
        d0 = done_seen;
        go(2, 3, 4);
        tick();
        ready = 1'b0;
        start = 1'b1; start_code = 3'd7; step = 3'd1; burst_len = 5'd2;
        tick();
        start = 1'b0;
        chk("stall_data1", 32'(data_out), 32'((2 + 3) % M));
        chk("stall_count1", 32'(count), 1);
        tick();
        chk("stall_data2", 32'(data_out), 32'((2 + 3) % M));
        chk("stall_valid2", 32'(valid), 1);
        chk("stall_count2", 32'(count), 1);
        ready = 1'b1;
        repeat (3) tick();
        chk("stall_done", 32'(done), 1);
        chk("stall_count", 32'(count), 4);
        tick();
        chk("stall_done_once", 32'(done_seen - d0), 1);

        // Abort on the third transfer.
        d0 = done_seen;
        go(3, 2, 6);
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 32'(valid), 0);
        chk("abort_count", 32'(count), 3);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_left", 32'(exp_q.size()), 3);
        exp_q.delete();
        repeat (2) tick();
        chk("abort_no_done", 32'(done_seen - d0), 0);

        // Normal burst after the abort.
        go(4, 1, 2);
        chk("post_abort_valid", 32'(valid), 1);
        repeat (2) tick();
        chk("post_abort_done", 32'(done), 1);
        tick();

        // Zero-length start and abort in IDLE do nothing.
        start = 1'b1; start_code = 3'd1; step = 3'd1; burst_len = 5'd0;
        abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("len0_valid", 32'(valid), 0);
        chk("len0_busy", 32'(busy), 0);
        chk("len0_count", 32'(count), 2);
        tick();
        chk("len0_done", 32'(done), 0);

        // Abort together with the final transfer: abort wins, transfer counts.
        d0 = done_seen;
        go(1, 1, 2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abfin_count", 32'(count), 2);
        chk("abfin_valid", 32'(valid), 0);
        tick();
        chk("abfin_no_done", 32'(done_seen - d0), 0);

        // Reset mid-burst, then a start on the first edge after release.
        d0 = done_seen;
        go(0, 1, 5);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("mrst_data", 32'(data_out), 0);
        chk("mrst_valid", 32'(valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_count", 32'(count), 0);
        chk("mrst_left", 32'(exp_q.size()), 3);
        exp_q.delete();
        tick();
        rst = 1'b0;
        go(2, 1, 3);
        chk("post_rst_valid", 32'(valid), 1);
        chk("post_rst_data", 32'(data_out), 2);
        repeat (3) tick();
        chk("post_rst_done", 32'(done), 1);
        chk("post_rst_count", 32'(count), 3);
        tick();
        chk("post_rst_done_once", 32'(done_seen - d0), 1);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
